dmg_timer: RTL and testbench

DataBus responder implementing the DMG timer registers DIV, TIMA, TMA and TAC at FF04–FF07, plus the timer interrupt request. It is bus-driven from the CPU side, the same way the graphics peripheral is. It sits beside whizgraphics on the shared peripheral bus; `timer_irq` feeds bit 2 of the interrupt controller. The bus side is a thin adapter from the DataBus peripheral modport onto the discrete ports below.

---
 rtl/dmg_timer.sv | 134 +++++++++++++
 tb/tb_dmg_timer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmg_timer.sv
// DMG timer block: DIV/TIMA/TMA/TAC registers at BASE_ADDR..BASE_ADDR+3 with overflow reload and irq.
// Define DMG_TIMER_GLITCH_EN to let write-induced tick falling edges increment TIMA.
module dmg_timer #(
  parameter logic [15:0] BASE_ADDR = 16'hFF04
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] bus_addr,
  input  logic [7:0]  bus_wdata,
  input  logic        bus_we,
  input  logic        bus_re,
  output logic [7:0]  bus_rdata,
  output logic        bus_hit,
  output logic        timer_irq,
  output logic        dbgState
);

  // Bus handshake: a strobe (bus_we or bus_re) is a single-clk request with no back-pressure;
  // a read is answered exactly one clk later by bus_hit=1 with bus_rdata, a write has no response.

  typedef enum logic {RUN = 1'b0, RELOAD = 1'b1} state_t;

  state_t      state;
  logic [15:0] divCtr;
  logic [7:0]  tima;
  logic [7:0]  tma;
  logic [2:0]  tac;
  logic        tickPrev;

  logic        inRange;
  logic [1:0]  regSel;
  logic        wrDiv, wrTima, wrTma, wrTac;
  logic        tickSig, tickFall, timaInc, tickNext;
  logic [7:0]  readVal;

  function automatic logic selBit(input logic [15:0] d, input logic [1:0] s);
    case (s)
      2'b00:   selBit = d[9];
      2'b01:   selBit = d[3];
      2'b10:   selBit = d[5];
      default: selBit = d[7];
    endcase
  endfunction

  assign inRange = (bus_addr >= BASE_ADDR) && (bus_addr <= BASE_ADDR + 16'd3);
  assign regSel  = bus_addr[1:0] - BASE_ADDR[1:0];
  assign wrDiv   = bus_we && inRange && (regSel == 2'd0);
  assign wrTima  = bus_we && inRange && (regSel == 2'd1);
  assign wrTma   = bus_we && inRange && (regSel == 2'd2);
  assign wrTac   = bus_we && inRange && (regSel == 2'd3);

  assign tickSig  = tac[2] & selBit(divCtr, tac[1:0]);
  assign tickFall = tickPrev & ~tickSig;

`ifdef DMG_TIMER_GLITCH_EN
  assign timaInc  = tickFall;
  assign tickNext = tickSig;
`else
  // Seed the history with the post-write tick value so a CPU write never looks like a falling edge.
  assign timaInc = tickFall & ~(wrDiv | wrTac);
  always_comb begin
    tickNext = tickSig;
    if (wrDiv)
      tickNext = 1'b0;
    else if (wrTac)
      tickNext = bus_wdata[2] & selBit(divCtr + 16'd1, bus_wdata[1:0]);
  end
`endif

  always_comb begin
    case (regSel)
      2'd0:    readVal = divCtr[15:8];
      2'd1:    readVal = tima;
      2'd2:    readVal = tma;
      default: readVal = {5'b11111, tac};
    endcase
  end

  assign dbgState = (state == RELOAD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      divCtr    <= 16'h0000;
      tima      <= 8'h00;
      tma       <= 8'h00;
      tac       <= 3'b000;
      tickPrev  <= 1'b0;
      bus_rdata <= 8'h00;
      bus_hit   <= 1'b0;
      timer_irq <= 1'b0;
    end else begin
      divCtr    <= wrDiv ? 16'h0000 : divCtr + 16'd1;
      tickPrev  <= tickNext;
      timer_irq <= 1'b0;
      if (wrTma) tma <= bus_wdata;
      if (wrTac) tac <= bus_wdata[2:0];

      case (state)
        RUN: begin
          if (wrTima) begin
            tima <= bus_wdata;
          end else if (timaInc) begin
            if (tima == 8'hFF) begin
              tima  <= 8'h00;
              state <= RELOAD;
            end else begin
              tima <= tima + 8'd1;
            end
          end
        end
        RELOAD: begin
          // A TIMA write here cancels the reload; a same-clk TMA write is what gets loaded.
          state <= RUN;
          if (wrTima) begin
            tima <= bus_wdata;
          end else begin
            tima      <= wrTma ? bus_wdata : tma;
            timer_irq <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase

      if (bus_re && inRange) begin
        bus_rdata <= readVal;
        bus_hit   <= 1'b1;
      end else begin
        bus_hit <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dmg_timer.sv
// Bench for dmg_timer: directed scenarios plus randomized bus traffic against an arithmetic reference model.
module tb_dmg_timer;

  logic        clk;
  logic        reset;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_we;
  logic        bus_re;
  logic [7:0]  bus_rdata;
  logic        bus_hit;
  logic        timer_irq;
  logic        dbgState;

  dmg_timer dut (
    .clk       (clk),
    .reset     (reset),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_we    (bus_we),
    .bus_re    (bus_re),
    .bus_rdata (bus_rdata),
    .bus_hit   (bus_hit),
    .timer_irq (timer_irq),
    .dbgState  (dbgState)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checkCnt = 0;
  int passCnt  = 0;
  int irqCount = 0;
  bit checkOn  = 1'b0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checkCnt++;
    if (got === exp) passCnt++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [7:0] exp_q[$];
  int mDiv = 0, mTima = 0, mTma = 0, mTac = 0;
  bit mReload = 1'b0, mPrev = 1'b0, expHit = 1'b0, expIrq = 1'b0;

  // Selected DIV bit is high during the upper half of each period of that bit.
  function automatic bit tickOf(input int div, input int tac);
    int sh;
    if ((tac & 4) == 0) return 1'b0;
    case (tac & 3)
      0: sh = 9;
      1: sh = 3;
      2: sh = 5;
      default: sh = 7;
    endcase
    return (div % (2 << sh)) >= (1 << sh);
  endfunction

  always @(posedge clk) begin : model
    int idx, rv, nDiv, nTac, nTma, wd;
    bit sel, wr, rd, tick, fall, inc, cpuTouch;
    if (reset) begin
      mDiv = 0; mTima = 0; mTma = 0; mTac = 0;
      mReload = 0; mPrev = 0; expHit = 0; expIrq = 0;
      exp_q.delete();
    end else begin
      sel = (bus_addr >= 16'hFF04) && (bus_addr <= 16'hFF07);
      idx = int'(bus_addr) - 32'hFF04;
      wd  = int'(bus_wdata);
      wr  = bus_we && sel;
      rd  = bus_re && sel;
      case (idx)
        0: rv = mDiv / 256;
        1: rv = mTima;
        2: rv = mTma;
        default: rv = 248 + mTac;
      endcase
      cpuTouch = wr && (idx == 0 || idx == 3);
      tick = tickOf(mDiv, mTac);
      fall = mPrev && !tick;
      nDiv = (wr && idx == 0) ? 0 : (mDiv + 1) % 65536;
      nTac = (wr && idx == 3) ? (wd % 8) : mTac;
      nTma = (wr && idx == 2) ? wd : mTma;
`ifdef DMG_TIMER_GLITCH_EN
      inc   = fall;
      mPrev = tick;
`else
      inc   = fall && !cpuTouch;
      mPrev = cpuTouch ? tickOf(nDiv, nTac) : tick;
`endif
      expIrq = 0;
      if (wr && idx == 1) begin
        mTima = wd; mReload = 0;
      end else if (mReload) begin
        mTima = nTma; mReload = 0; expIrq = 1;
      end else if (inc) begin
        if (mTima == 255) begin mTima = 0; mReload = 1; end
        else mTima = mTima + 1;
      end
      mDiv = nDiv; mTac = nTac; mTma = nTma;
      expHit = rd;
      if (rd) exp_q.push_back(8'(rv));
    end
  end

  // ---------------- scoreboard (sampled on falling edge) ----------------
  always @(negedge clk) begin
    logic [7:0] e;
    if (timer_irq) irqCount++;
    if (checkOn) begin
      check("hit", 16'(bus_hit), 16'(expHit));
      if (expHit) begin
        if (exp_q.size() == 0) check("exp_q_empty", 16'(1), 16'(0));
        else begin
          e = exp_q.pop_front();
          check("rdata", 16'(bus_rdata), 16'(e));
        end
      end
      check("irq", 16'(timer_irq), 16'(expIrq));
      check("state", 16'(dbgState), 16'(mReload));
    end
  end

  // ---------------- driver tasks (drive at negedge+1) ----------------
  task automatic cycle();
    @(negedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic busWrite(input logic [15:0] a, input logic [7:0] d);
    bus_addr = a; bus_wdata = d; bus_we = 1'b1;
    cycle();
    bus_we = 1'b0;
  endtask

  task automatic busRead(input logic [15:0] a, output logic [7:0] d);
    bus_addr = a; bus_re = 1'b1;
    cycle();
    bus_re = 1'b0;
    d = bus_rdata;
  endtask

  // Stop the timer, load TMA/TIMA, align DIV at edge D, enable TAC=101 at D+1.
  task automatic setupAligned(input logic [7:0] tmaV, input logic [7:0] timaV);
    busWrite(16'hFF07, 8'h00);
    busWrite(16'hFF06, tmaV);
    busWrite(16'hFF05, timaV);
    busWrite(16'hFF04, 8'h5A);
    busWrite(16'hFF07, 8'h05);
  endtask

  initial begin : watchdog
    #(90000 * 10);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] d;
    reset = 1'b1; bus_addr = 16'h0000; bus_wdata = 8'h00; bus_we = 1'b0; bus_re = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    reset = 1'b0;
    checkOn = 1'b1;

    // Reset values
    busRead(16'hFF04, d); check("rst_div", 16'(d), 16'h00);
    busRead(16'hFF05, d); check("rst_tima", 16'(d), 16'h00);
    busRead(16'hFF06, d); check("rst_tma", 16'(d), 16'h00);
    busRead(16'hFF07, d); check("rst_tac", 16'(d), 16'hF8);

    // Period-16 counting: increments land at D+16k+1
    setupAligned(8'h00, 8'h00);
    idle(160);
    busRead(16'hFF05, d); check("tima_0A", 16'(d), 16'h0A);
    idle(15);
    busRead(16'hFF05, d); check("tima_0B", 16'(d), 16'h0B);

    // Overflow: FF at D+17, wrap at D+33, reload+irq at D+34
    setupAligned(8'h80, 8'hFE);
    irqCount = 0;
    idle(30);
    busRead(16'hFF05, d); check("ovf_ff_a", 16'(d), 16'hFF);
    busRead(16'hFF05, d); check("ovf_ff_b", 16'(d), 16'hFF);
    busRead(16'hFF05, d); check("ovf_reload", 16'(d), 16'h00);
    busRead(16'hFF05, d); check("ovf_loaded", 16'(d), 16'h80);
    idle(4);
    check("ovf_irq_count", 16'(irqCount), 16'd1);

    // TIMA write during the reload clk cancels load and irq
    setupAligned(8'h80, 8'hFE);
    irqCount = 0;
    idle(32);
    busWrite(16'hFF05, 8'h33);
    busRead(16'hFF05, d); check("cancel_tima", 16'(d), 16'h33);
    idle(4);
    check("cancel_irq_count", 16'(irqCount), 16'd0);

    // Write coinciding with a scheduled increment wins
    setupAligned(8'h00, 8'h05);
    idle(15);
    busWrite(16'hFF05, 8'h10);
    busRead(16'hFF05, d); check("wr_wins", 16'(d), 16'h10);

    // DIV write while the selected bit is high
    setupAligned(8'h00, 8'h20);
    idle(8);
    busWrite(16'hFF04, 8'hFF);
    busRead(16'hFF04, d); check("divwr_div", 16'(d), 16'h00);
    busRead(16'hFF05, d);
`ifdef DMG_TIMER_GLITCH_EN
    check("divwr_tima", 16'(d), 16'h21);
`else
    check("divwr_tima", 16'(d), 16'h20);
`endif

    // Reset during the reload clk: no irq, everything back to reset values
    setupAligned(8'h80, 8'hFE);
    idle(32);
    irqCount = 0;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    idle(3);
    check("rst_reload_irq", 16'(irqCount), 16'd0);
    busRead(16'hFF05, d); check("rst_reload_tima", 16'(d), 16'h00);

    // Randomized traffic, checked by the scoreboard every cycle
    for (int i = 0; i < 4000; i++) begin
      bus_addr  = 16'hFF03 + 16'($urandom_range(0, 5));
      bus_we    = ($urandom_range(0, 2) == 0);
      bus_re    = ($urandom_range(0, 1) == 1);
      bus_wdata = 8'($urandom_range(0, 255));
      if (bus_addr == 16'hFF07 && $urandom_range(0, 3) != 0) bus_wdata[2] = 1'b1;
      if (bus_addr == 16'hFF05 && $urandom_range(0, 1) == 1) bus_wdata = bus_wdata | 8'hF8;
      if (bus_addr == 16'hFF04 && $urandom_range(0, 3) != 0) bus_we = 1'b0;
      cycle();
      bus_we = 1'b0; bus_re = 1'b0;
      idle($urandom_range(0, 6));
      if ($urandom_range(0, 599) == 0) begin
        reset = 1'b1;
        cycle();
        reset = 1'b0;
      end
    end
    idle(3);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
